prg_share_ctrl: RTL and testbench
=================================

// Module: prg_share_ctrl
// PURPOSE
//  Upstream feeder and downstream collector for the 3-share masked S-box (prg).
//  - Accepts one plain byte over a valid/ready handshake.
//  - Splits it into three Boolean shares using LFSR masks, and supplies fresh R0/R1.
//  - Holds shares and randomness stable for the S-box pipeline latency.
//  - Recombines out1^out2^out3 into one result byte, returned over a valid/ready handshake.
// PARAMETERS
//  SBOX_LAT   4              clock edges from stable shares to valid prg outputs; 0..15
//  LFSR_SEED  32'hACE12468   LFSR reset value; also used when a zero seed is loaded
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous reset, active-low
//  seed_load  in   1   load seed into LFSR this edge
//  seed       in   32  LFSR seed
//  in_valid   in   1   in_byte valid
//  in_ready   out  1   block can accept in_byte (IDLE)
//  in_byte    in   8   unmasked input byte
//  sh1,sh2,sh3 out 8   shares to prg in1/in2/in3
//  r0,r1      out  8   randomness to prg R0/R1
//  o1,o2,o3   in   8   prg out1/out2/out3
//  out_valid  out  1   out_byte valid
//  out_ready  in   1   consumer accepts out_byte
//  out_byte   out  8   recombined result o1^o2^o3
//  busy       out  1   operation in flight (WAIT or DONE)
// BEHAVIOUR
//  Reset (rst==0 at an edge):
//   - state=IDLE, in_ready=1, out_valid=0, busy=0.
//   - sh1..3, r0, r1 and out_byte = 0; cnt=0; lfsr=LFSR_SEED.
//   - Reset mid-operation aborts the operation; no out_valid is produced.
//  LFSR: 32-bit Galois, one step every cycle.
//   - next = {1'b0,s[31:1]} ^ (s[0] ? 32'h80200003 : 0).
//   - seed_load has priority over stepping: lfsr = (seed==0) ? LFSR_SEED : seed.
//   - The LFSR never holds 0.
//  FSM IDLE -> WAIT -> DONE -> IDLE.
//   IDLE: in_ready=1. On an accept edge (in_valid&in_ready), use the current (pre-edge) lfsr value L:
//    - sh1 = L[7:0]; sh2 = L[15:8]; sh3 = in_byte^L[7:0]^L[15:8].
//    - r0 = L[23:16]; r1 = L[31:24].
//    - cnt = SBOX_LAT; go WAIT.
//   WAIT: in_ready=0, busy=1.
//    - sh* and r* are held constant.
//    - cnt!=0: cnt decrements. cnt==0: out_byte = o1^o2^o3 and out_valid=1; go DONE.
//    - Latency from accept edge to out_valid high is SBOX_LAT+1 cycles.
//   DONE: out_valid=1, out_byte held, busy=1.
//    - On out_ready: out_valid=0; go IDLE.
//    - Earliest next accept is the edge after out_valid drops.
//  Boundary conditions:
//   - seed_load on the same edge as an accept: masks come from pre-load L; the LFSR then takes the seed.
//   - seed_load during WAIT/DONE reloads the LFSR only; the in-flight sh*/r* are unaffected.
//   - in_valid during WAIT/DONE is ignored (in_ready=0); the producer holds its byte.
//   - sh*/r* keep their last values after DONE until the next accept.
//   - out_byte is independent of the mask values.
//   - SBOX_LAT=0 captures on the edge after accept.
// TESTING
//  1. Reset: rst=0 for 2 cycles -> in_ready=1, out_valid=0, busy=0, sh*=r*=out_byte=0x00.
//  2. seed_load with seed=0x00000001, then accept in_byte=0xA5 on the next edge:
//     - sh1=0x01, sh2=0x00, sh3=0xA4, r0=r1=0x00.
//     - The following cycle lfsr=0x80200003.
//  3. SBOX_LAT=4, out_ready=1 -> out_valid rises exactly 5 cycles after accept; out_byte equals o1^o2^o3 at capture.
//  4. Mask independence: all 256 in_byte values with seed 0x00000001, then with 0xDEADBEEF:
//     - out_byte sequences are identical.
//     - Each equals the golden unmasked prg model.
//  5. Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid/out_byte stable, in_ready=0; second in_valid is not accepted.
//  6. rst=0 in WAIT at cnt=2 -> next cycle IDLE, no out_valid pulse; seed=0 load -> lfsr=LFSR_SEED.

Source files
------------

// File: rtl/prg_share_ctrl.sv
// prg_share_ctrl: feeder/collector around the 3-share masked S-box (prg).
// Accepts one plain byte, splits it into three Boolean shares with LFSR masks,
// supplies fresh R0/R1, holds everything stable for the S-box latency, then
// recombines the three output shares into one result byte.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-low reset
//   seed_load, seed   reload the LFSR (zero seed maps to LFSR_SEED)
//   in_valid/in_ready/in_byte     input handshake, unmasked byte
//   sh1, sh2, sh3     shares to prg in1/in2/in3
//   r0, r1            randomness to prg R0/R1
//   o1, o2, o3        prg output shares
//   out_valid/out_ready/out_byte  result handshake, o1^o2^o3
//   busy              operation in flight
module prg_share_ctrl #(
  parameter int unsigned SBOX_LAT  = 4,
  parameter logic [31:0] LFSR_SEED = 32'hACE12468,
  localparam int unsigned BYTE_W   = 8,
  localparam int unsigned LFSR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_byte,
  output logic [BYTE_W-1:0] sh1,
  output logic [BYTE_W-1:0] sh2,
  output logic [BYTE_W-1:0] sh3,
  output logic [BYTE_W-1:0] r0,
  output logic [BYTE_W-1:0] r1,
  input  logic [BYTE_W-1:0] o1,
  input  logic [BYTE_W-1:0] o2,
  input  logic [BYTE_W-1:0] o3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ST_W  = 2;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h80200003;

  localparam logic [ST_W-1:0] S_IDLE = 2'd0;
  localparam logic [ST_W-1:0] S_WAIT = 2'd1;
  localparam logic [ST_W-1:0] S_DONE = 2'd2;

  logic [ST_W-1:0]   state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [LFSR_W-1:0] lfsr, lfsr_n;
  logic [BYTE_W-1:0] sh1_n, sh2_n, sh3_n, r0_n, r1_n, out_byte_n;
  logic              out_valid_n, in_ready_n, busy_n;

  // One Galois step; a nonzero state never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lfsr      <= LFSR_SEED;
      sh1       <= '0;
      sh2       <= '0;
      sh3       <= '0;
      r0        <= '0;
      r1        <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lfsr      <= lfsr_n;
      sh1       <= sh1_n;
      sh2       <= sh2_n;
      sh3       <= sh3_n;
      r0        <= r0_n;
      r1        <= r1_n;
      out_byte  <= out_byte_n;
      out_valid <= out_valid_n;
      in_ready  <= in_ready_n;
      busy      <= busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh1_n       = sh1;
    sh2_n       = sh2;
    sh3_n       = sh3;
    r0_n        = r0;
    r1_n        = r1;
    out_byte_n  = out_byte;
    out_valid_n = out_valid;

    // A seed load wins over stepping; zero seed would lock the LFSR.
    if (seed_load) begin
      lfsr_n = (seed == '0) ? LFSR_SEED : seed;
    end else begin
      lfsr_n = lfsr_step(lfsr);
    end

    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          // Masks come from the pre-edge LFSR value, even on a seed load edge.
          sh1_n   = lfsr[7:0];
          sh2_n   = lfsr[15:8];
          sh3_n   = in_byte ^ lfsr[7:0] ^ lfsr[15:8];
          r0_n    = lfsr[23:16];
          r1_n    = lfsr[31:24];
          cnt_n   = CNT_W'(SBOX_LAT);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          out_byte_n  = o1 ^ o2 ^ o3;
          out_valid_n = 1'b1;
          state_n     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = S_IDLE;
        end
      end
      default: begin
        out_valid_n = 1'b0;
        state_n     = S_IDLE;
      end
    endcase

    in_ready_n = (state_n == S_IDLE);
    busy_n     = (state_n != S_IDLE);
  end

  // The LFSR must never lock up at zero.
  a_lfsr_nonzero: assert property (@(posedge clk) disable iff (!rst) lfsr != '0);

  // Input ready and busy are mutually exclusive views of the state.
  a_ready_busy: assert property (@(posedge clk) disable iff (!rst) in_ready != busy);

  // Shares and randomness must not move while the S-box is computing.
  a_hold_wait: assert property (@(posedge clk) disable iff (!rst)
    (state == S_WAIT) |=> $stable({sh1, sh2, sh3, r0, r1}));

endmodule

// File: tb/tb_prg_share_ctrl.sv
// Testbench for prg_share_ctrl with a behavioural masked prg pipeline model.
module tb_prg_share_ctrl;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [31:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic [7:0]  sh1, sh2, sh3, r0, r1;
  logic [7:0]  o1, o2, o3;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        busy;

  always #5 clk = ~clk;

  prg_share_ctrl #(.SBOX_LAT(LAT), .LFSR_SEED(32'hACE12468)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .sh1(sh1), .sh2(sh2), .sh3(sh3), .r0(r0), .r1(r1),
    .o1(o1), .o2(o2), .o3(o3),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .busy(busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0]  in_b;
    logic [7:0]  exp_out;
    bit          chk_sh;
    logic [39:0] exp_sh;
    int          acc;
  } txn_t;

  txn_t       sbq[$];
  logic [7:0] got_log[$];

  // Unmasked reference S-box (affine rotate-xor).
  function automatic logic [7:0] golden(input logic [7:0] x);
    logic [7:0] a, b;
    a = {x[6:0], x[7]};
    b = {x[5:0], x[7:6]};
    return x ^ a ^ b ^ 8'h63;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Masked prg model: LAT register stages, output shares sum to golden(x).
  logic [39:0] pipe [LAT];
  logic [39:0] tail;
  always @(posedge clk) begin
    pipe[0] <= {sh1, sh2, sh3, r0, r1};
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  always_comb begin
    tail = pipe[LAT-1];
    o1   = golden(tail[39:32] ^ tail[31:24] ^ tail[23:16]) ^ tail[15:8];
    o2   = tail[7:0] ^ tail[39:32];
    o3   = tail[15:8] ^ tail[7:0] ^ tail[39:32];
  end

  // Monitor: compares DUT outputs against the scoreboard queue.
  logic       rst_q = 1'b1;
  logic       prev_ov = 1'b0;
  logic       prev_hs = 1'b0;
  logic [7:0] prev_ob = 8'h00;
  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (!rst_q) begin
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_shares", {sh1, sh2, sh3, r0}, 32'd0);
      chk("rst_r1_out", {16'd0, r1, out_byte}, 32'd0);
      sbq.delete();
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_done", 32'(in_ready), 32'd0);
        chk("busy_done", 32'(busy), 32'd1);
      end
      if (out_valid && !prev_ov) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out_valid actual=1 required=0 out_byte=0x%0h", out_byte);
        end else begin
          chk("latency", 32'(cyc - sbq[0].acc), 32'(LAT + 1));
          chk("out_byte", 32'(out_byte), 32'(sbq[0].exp_out));
          chk("share_xor", 32'(sh1 ^ sh2 ^ sh3), 32'(sbq[0].in_b));
          if (sbq[0].chk_sh) begin
            chk("shares", {sh1, sh2, sh3, r0}, sbq[0].exp_sh[39:8]);
            chk("r1", 32'(r1), 32'(sbq[0].exp_sh[7:0]));
          end
        end
      end
      if (out_valid && prev_ov && !prev_hs) begin
        chk("out_byte_stable", 32'(out_byte), 32'(prev_ob));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() != 0) void'(sbq.pop_front());
        got_log.push_back(out_byte);
      end
      prev_ov = out_valid;
      prev_ob = out_byte;
      prev_hs = out_valid && out_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte, wait for acceptance, and push its expected response.
  task automatic send(input logic [7:0] b, input bit csh, input logic [39:0] esh,
                      input bit ld, input logic [31:0] ls);
    txn_t t;
    int   n;
    in_valid = 1'b1;
    in_byte  = b;
    if (ld) begin
      seed_load = 1'b1;
      seed      = ls;
    end
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout byte=0x%0h in_ready=%0d required=1", b, in_ready);
      in_valid = 1'b0;
      return;
    end
    t.in_b    = b;
    t.exp_out = golden(b);
    t.chk_sh  = csh;
    t.exp_sh  = esh;
    t.acc     = cyc + 1;
    sbq.push_back(t);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_byte   = 8'hEE;
    seed_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
      sbq.delete();
    end
    tick();
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_load = 1'b1;
    seed      = s;
    tick();
    seed_load = 1'b0;
  endtask

  logic [7:0] log_a[$];
  int         mism;
  int         n;

  initial begin
    rst = 1'b0; seed_load = 1'b0; seed = '0;
    in_valid = 1'b0; in_byte = '0; out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Seed 1, accept on next edge: masks from L=1.
    load_seed(32'h00000001);
    send(8'hA5, 1'b1, {8'h01, 8'h00, 8'hA4, 8'h00, 8'h00}, 1'b0, '0);
    drain();

    // One idle step after seed 1 gives L=0x80200003.
    load_seed(32'h00000001);
    tick();
    send(8'h3C, 1'b1, {8'h03, 8'h00, 8'h3F, 8'h20, 8'h80}, 1'b0, '0);
    drain();

    // Seed load on the accept edge: masks still from pre-load L=1.
    load_seed(32'h00000001);
    send(8'h5A, 1'b1, {8'h01, 8'h00, 8'h5B, 8'h00, 8'h00}, 1'b1, 32'h12345678);
    // Reload during WAIT/DONE; in-flight shares must stay as above.
    seed_load = 1'b1;
    seed      = 32'hC0FFEE11;
    send(8'h77, 1'b1, {8'h11, 8'hEE, 8'h88, 8'hFF, 8'hC0}, 1'b1, 32'hC0FFEE11);
    drain();

    // All 256 bytes under two different seeds.
    got_log.delete();
    load_seed(32'h00000001);
    for (int b = 0; b < 256; b++) send(8'(b), 1'b0, '0, 1'b0, '0);
    drain();
    log_a = got_log;
    got_log.delete();
    load_seed(32'hDEADBEEF);
    for (int b = 0; b < 256; b++) send(8'(b), 1'b0, '0, 1'b0, '0);
    drain();
    chk("mask_indep_len", 32'(got_log.size()), 32'(log_a.size()));
    mism = 0;
    for (int i = 0; i < 256 && i < got_log.size() && i < log_a.size(); i++)
      if (got_log[i] !== log_a[i]) mism++;
    chk("mask_indep_seq", 32'(mism), 32'd0);

    // Backpressure in DONE with a second byte waiting.
    out_ready = 1'b0;
    send(8'hC3, 1'b0, '0, 1'b0, '0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_byte  = 8'h99;
    repeat (10) @(negedge clk);
    out_ready = 1'b1;
    send(8'h99, 1'b0, '0, 1'b0, '0);
    drain();

    // Reset while in WAIT with cnt==2: abort, no result.
    send(8'h42, 1'b0, '0, 1'b0, '0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (12) tick();

    // Zero seed load falls back to 0xACE12468.
    load_seed(32'h00000000);
    send(8'h11, 1'b1, {8'h68, 8'h24, 8'h5D, 8'hE1, 8'hAC}, 1'b0, '0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog elapsed=%0t required=finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
